// File: rtl/argmax_sequencer.sv
// Sequential argmax back-end: streams NUM_CLASSES scores through one shared comparator and
// hands the winning class index out on a valid/ready port. Build macro ARGMAX_SIGNED_EN selects signed comparison.
module argmax_sequencer #(
    parameter int NUM_CLASSES = 10,
    parameter int SCORE_W     = 26,
    parameter int IDX_W       = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               score_valid,
    input  logic [SCORE_W-1:0] score_data,
    output logic               score_ready,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [IDX_W-1:0]   class_out,
    output logic [SCORE_W-1:0] max_score,
    output logic               busy,
    output logic [15:0]        image_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] NO_RESULT  = IDX_W'(15);
    localparam logic [IDX_W-1:0] SLOT_ZERO  = {IDX_W{1'b0}};

    state_t               state_r;
    logic [IDX_W-1:0]     slot_r;
    logic [IDX_W-1:0]     class_r;
    logic [SCORE_W-1:0]   max_r;
    logic [15:0]          image_count_r;
    logic                 score_ready_r;
    logic                 result_valid_r;
    logic                 busy_r;

    logic                 accept_s;
    logic                 last_s;
    logic                 take_s;
    logic                 handoff_s;

    // The single shared comparator; the build macro only changes how bits are interpreted.
    function automatic logic score_gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
`ifdef ARGMAX_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Accept / compare / hand-off qualifiers derived from registered state.
    always_comb begin
        accept_s  = score_valid && score_ready_r;
        last_s    = (slot_r == LAST_SLOT);
        handoff_s = result_valid_r && result_ready;
        if (slot_r == SLOT_ZERO) begin
            take_s = 1'b1;
        end else begin
            take_s = score_gt(score_data, max_r);
        end
    end

    // Control FSM with registered handshake outputs and running-maximum datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            slot_r         <= SLOT_ZERO;
            class_r        <= NO_RESULT;
            max_r          <= {SCORE_W{1'b0}};
            image_count_r  <= 16'd0;
            score_ready_r  <= 1'b0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r       <= ST_COLLECT;
                        slot_r        <= SLOT_ZERO;
                        score_ready_r <= 1'b1;
                        busy_r        <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (accept_s) begin
                        // Strict compare keeps the lower index on ties.
                        if (take_s) begin
                            max_r   <= score_data;
                            class_r <= slot_r;
                        end
                        slot_r <= slot_r + IDX_W'(1);
                        if (last_s) begin
                            state_r        <= ST_DONE;
                            score_ready_r  <= 1'b0;
                            result_valid_r <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (handoff_s) begin
                        state_r        <= ST_IDLE;
                        result_valid_r <= 1'b0;
                        busy_r         <= 1'b0;
                        image_count_r  <= image_count_r + 16'd1;
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    slot_r         <= SLOT_ZERO;
                    score_ready_r  <= 1'b0;
                    result_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                end
            endcase
        end
    end

    assign score_ready  = score_ready_r;
    assign result_valid = result_valid_r;
    assign class_out    = class_r;
    assign max_score    = max_r;
    assign busy         = busy_r;
    assign image_count  = image_count_r;

endmodule
